// File: rtl/mem_read_seq.sv
// mem_read_seq
//   Read-side sequencer for the 16-bit register/memory storage. Takes a burst
//   read command (start address, word count) and issues one read at a time to
//   a synchronous-read memory port. Each returned word is captured into a
//   holding register and offered downstream on a valid/ready handshake.
//
// Ports
//   CLK         in   1       clock, all state changes on posedge
//   RES_N       in   1       asynchronous active-low reset
//   start       in   1       burst request, sampled only while idle
//   start_addr  in   ADDR_W  first word address of the burst
//   start_len   in   LEN_W   number of words to read (0 allowed)
//   busy        out  1       burst in progress
//   done        out  1       one-cycle pulse when the burst completes
//   mem_re      out  1       read enable, one-cycle pulse per word
//   mem_addr    out  ADDR_W  read address, valid while mem_re=1
//   mem_rdata   in   DATA_W  memory data, valid RD_LAT cycles after mem_re
//   out_data    out  DATA_W  captured word
//   out_valid   out  1       out_data holds an unconsumed word
//   out_ready   in   1       downstream accepts word when out_valid&out_ready
module mem_read_seq #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8,
   parameter int RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              RES_N,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  start_len,
   output logic              busy,
   output logic              done,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [LEN_W-1:0]  rem_q, rem_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic [DATA_W-1:0] data_q, data_nxt;
   logic              done_q, done_nxt;

   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         addr_q <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         done_q <= 1'b0;
      end else begin
         addr_q <= addr_nxt;
         rem_q  <= rem_nxt;
         cnt_q  <= cnt_nxt;
         data_q <= data_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_q;
      rem_nxt   = rem_q;
      cnt_nxt   = cnt_q;
      data_nxt  = data_q;
      done_nxt  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               if (start_len != '0) begin
                  addr_nxt  = start_addr;
                  rem_nxt   = start_len;
                  state_nxt = S_ISSUE;
               end else begin
                  // empty burst: complete immediately without touching memory
                  done_nxt = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // the last WAIT cycle is exactly RD_LAT cycles after the read
            if (cnt_q == CNT_LAST) begin
               data_nxt  = mem_rdata;
               state_nxt = S_HOLD;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               addr_nxt = addr_q + ADDR_W'(1);
               rem_nxt  = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_ISSUE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      busy      = (state != S_IDLE);
      mem_re    = (state == S_ISSUE);
      out_valid = (state == S_HOLD);
      mem_addr  = addr_q;
      out_data  = data_q;
      done      = done_q;
   end

endmodule

// File: tb/tb_mem_read_seq.sv
// tb_mem_read_seq
//   Directed bench for mem_read_seq. Instance u1 uses RD_LAT=1, instance u3
//   uses RD_LAT=3. Each has a memory model returning 0xA000|addr exactly
//   RD_LAT cycles after the read and 0x0BAD in every other cycle.
module tb_mem_read_seq;

   logic        CLK = 1'b0;
   logic        RES_N = 1'b0;

   logic        start, out_ready;
   logic [7:0]  start_addr, start_len;
   logic        busy, done, mem_re, out_valid;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata, out_data;

   logic        b_start, b_out_ready;
   logic [7:0]  b_start_addr, b_start_len;
   logic        b_busy, b_done, b_mem_re, b_out_valid;
   logic [7:0]  b_mem_addr;
   logic [15:0] b_mem_rdata, b_out_data;

   int n_cmp = 0;
   int n_bad = 0;
   int re_cnt, done_cnt, b_done_cnt;
   logic [15:0] q_addr[$];
   logic [15:0] q_out[$];
   logic [15:0] q_bout[$];
   logic [15:0] m1;
   logic [15:0] m3 [3];

   always #5 CLK = ~CLK;

   mem_read_seq #(.DATA_W(16), .ADDR_W(8), .LEN_W(8), .RD_LAT(1)) u1 (
      .CLK(CLK), .RES_N(RES_N), .start(start), .start_addr(start_addr),
      .start_len(start_len), .busy(busy), .done(done), .mem_re(mem_re),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   mem_read_seq #(.DATA_W(16), .ADDR_W(8), .LEN_W(8), .RD_LAT(3)) u3 (
      .CLK(CLK), .RES_N(RES_N), .start(b_start), .start_addr(b_start_addr),
      .start_len(b_start_len), .busy(b_busy), .done(b_done), .mem_re(b_mem_re),
      .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata), .out_data(b_out_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   // memory models
   always @(posedge CLK) m1 <= mem_re ? (16'hA000 | 16'(mem_addr)) : 16'h0BAD;
   assign mem_rdata = m1;

   always @(posedge CLK) begin
      m3[0] <= b_mem_re ? (16'hA000 | 16'(b_mem_addr)) : 16'h0BAD;
      m3[1] <= m3[0];
      m3[2] <= m3[1];
   end
   assign b_mem_rdata = m3[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // monitors sample on the falling edge, inputs change just after rising edge
   always @(negedge CLK) begin
      if (RES_N) begin
         if (mem_re) begin
            q_addr.push_back(16'(mem_addr));
            re_cnt++;
         end
         if (out_valid && out_ready) q_out.push_back(out_data);
         if (done) begin
            done_cnt++;
            chk("u1_done_excl_valid", 32'(out_valid), 32'd0);
         end
         if (b_out_valid && b_out_ready) q_bout.push_back(b_out_data);
         if (b_done) begin
            b_done_cnt++;
            chk("u3_done_excl_valid", 32'(b_out_valid), 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_out.delete();
      q_bout.delete();
      re_cnt     = 0;
      done_cnt   = 0;
      b_done_cnt = 0;
   endtask

   task automatic fire(input logic [7:0] a, input logic [7:0] l);
      start_addr = a;
      start_len  = l;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done !== 1'b1 && k < 60) begin
         step();
         k++;
      end
      chk(tag, 32'(done), 32'd1);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      start = 0; start_addr = '0; start_len = '0; out_ready = 0;
      b_start = 0; b_start_addr = '0; b_start_len = '0; b_out_ready = 0;
      clear_log();

      // reset state
      repeat (3) step();
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_mem_re",    32'(mem_re),    32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      RES_N = 1'b1;
      step();

      // 1: basic burst, RD_LAT=1
      clear_log();
      out_ready = 1'b1;
      fire(8'h10, 8'd3);
      chk("t1_c1_mem_re",   32'(mem_re),    32'd1);
      chk("t1_c1_mem_addr", 32'(mem_addr),  32'h10);
      chk("t1_c1_busy",     32'(busy),      32'd1);
      step();
      chk("t1_c2_valid",    32'(out_valid), 32'd0);
      step();
      chk("t1_c3_valid",    32'(out_valid), 32'd1);
      chk("t1_c3_data",     32'(out_data),  32'hA010);
      wait_done("t1_done_seen");
      chk("t1_n_addr", 32'(q_addr.size()), 32'd3);
      chk("t1_addr0", 32'(q_addr[0]), 32'h10);
      chk("t1_addr1", 32'(q_addr[1]), 32'h11);
      chk("t1_addr2", 32'(q_addr[2]), 32'h12);
      chk("t1_n_out", 32'(q_out.size()), 32'd3);
      chk("t1_out0",  32'(q_out[0]), 32'hA010);
      chk("t1_out1",  32'(q_out[1]), 32'hA011);
      chk("t1_out2",  32'(q_out[2]), 32'hA012);
      chk("t1_done_cnt", 32'(done_cnt), 32'd1);
      chk("t1_busy_end", 32'(busy), 32'd0);

      // 2: backpressure
      clear_log();
      out_ready = 1'b0;
      fire(8'h20, 8'd2);
      begin
         int k = 0;
         while (!out_valid && k < 20) begin
            step();
            k++;
         end
      end
      chk("t2_valid_seen", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_data",  32'(out_data),  32'hA020);
         chk("t2_hold_valid", 32'(out_valid), 32'd1);
         chk("t2_hold_re",    32'(re_cnt),    32'd1);
         step();
      end
      out_ready = 1'b1;
      wait_done("t2_done_seen");
      chk("t2_n_out", 32'(q_out.size()), 32'd2);
      chk("t2_out0",  32'(q_out[0]), 32'hA020);
      chk("t2_out1",  32'(q_out[1]), 32'hA021);
      chk("t2_re_cnt", 32'(re_cnt), 32'd2);

      // 3: address wrap
      clear_log();
      fire(8'hFE, 8'd3);
      wait_done("t3_done_seen");
      chk("t3_addr0", 32'(q_addr[0]), 32'hFE);
      chk("t3_addr1", 32'(q_addr[1]), 32'hFF);
      chk("t3_addr2", 32'(q_addr[2]), 32'h00);
      chk("t3_out2",  32'(q_out[2]),  32'hA000);
      chk("t3_n_addr", 32'(q_addr.size()), 32'd3);

      // 4: zero-length burst
      clear_log();
      fire(8'h33, 8'd0);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      step();
      chk("t4_done_off", 32'(done), 32'd0);
      chk("t4_busy2",    32'(busy), 32'd0);
      repeat (3) step();
      chk("t4_re_cnt",   32'(re_cnt),   32'd0);
      chk("t4_done_cnt", 32'(done_cnt), 32'd1);

      // 5: reset mid-burst
      clear_log();
      fire(8'h40, 8'd4);
      step();
      chk("t5_busy_pre", 32'(busy), 32'd1);
      RES_N = 1'b0;
      #1;
      chk("t5_busy",      32'(busy),      32'd0);
      chk("t5_mem_re",    32'(mem_re),    32'd0);
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_mem_addr",  32'(mem_addr),  32'd0);
      chk("t5_out_data",  32'(out_data),  32'd0);
      chk("t5_done",      32'(done),      32'd0);
      repeat (2) step();
      RES_N = 1'b1;
      repeat (2) step();
      chk("t5_no_done", 32'(done_cnt), 32'd0);
      clear_log();
      fire(8'h50, 8'd1);
      chk("t5_new_re",   32'(mem_re),   32'd1);
      chk("t5_new_addr", 32'(mem_addr), 32'h50);
      wait_done("t5_done_seen");
      chk("t5_n_out", 32'(q_out.size()), 32'd1);
      chk("t5_out0",  32'(q_out[0]), 32'hA050);

      // 6a: start while busy is ignored
      clear_log();
      fire(8'h60, 8'd2);
      fire(8'h99, 8'd5);
      wait_done("t6_done_seen");
      repeat (5) step();
      chk("t6_n_addr", 32'(q_addr.size()), 32'd2);
      chk("t6_addr0",  32'(q_addr[0]), 32'h60);
      chk("t6_addr1",  32'(q_addr[1]), 32'h61);
      chk("t6_done_cnt", 32'(done_cnt), 32'd1);
      chk("t6_busy_end", 32'(busy), 32'd0);

      // 6b: RD_LAT=3 instance
      clear_log();
      b_out_ready  = 1'b1;
      b_start_addr = 8'h30;
      b_start_len  = 8'd2;
      b_start      = 1'b1;
      step();
      b_start = 1'b0;
      chk("t6b_c1_re",   32'(b_mem_re),   32'd1);
      chk("t6b_c1_addr", 32'(b_mem_addr), 32'h30);
      for (int c = 2; c <= 4; c++) begin
         step();
         chk("t6b_wait_valid", 32'(b_out_valid), 32'd0);
      end
      step();
      chk("t6b_c5_valid", 32'(b_out_valid), 32'd1);
      chk("t6b_c5_data",  32'(b_out_data),  32'hA030);
      begin
         int k = 0;
         while (b_done !== 1'b1 && k < 60) begin
            step();
            k++;
         end
      end
      chk("t6b_done_seen", 32'(b_done), 32'd1);
      step();
      chk("t6b_n_out", 32'(q_bout.size()), 32'd2);
      chk("t6b_out0",  32'(q_bout[0]), 32'hA030);
      chk("t6b_out1",  32'(q_bout[1]), 32'hA031);
      chk("t6b_done_cnt", 32'(b_done_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
